// File: rtl/bcd_tick_counter_pkg.sv
// Shared encodings and constants for the BCD tick counter slice.
package bcd_tick_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_FULL  = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_tick_counter_digit.sv
// Single BCD decade register; wraps 9 -> 0 and ripples a carry to the next decade.
module bcd_digit
   import bcd_tick_counter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc_in,
   output logic [3:0] digit,
   output logic       carry_out
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (inc_in) begin
         digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
      end
   end

   assign carry_out = inc_in & (digit == BCD_MAX);

endmodule

// File: rtl/bcd_tick_counter.sv
// Decimal event counter: edge-detects the divided tick and counts rises in packed BCD
// under start/stop/clear control, with saturate-or-wrap behaviour at all-9s.
module bcd_tick_counter
   import bcd_tick_counter_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned STOP_AT_MAX = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick_in,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      clear,
   output logic [4*NUM_DIGITS-1:0]   bcd,
   output logic                      running,
   output logic                      full,
   output logic                      overflow
);

   state_t                state_q, state_d;
   logic                  tick_d;
   logic                  rise;
   logic                  inc;
   logic                  sat_hit;
   logic                  all_nines;
   logic                  overflow_q;
   logic [NUM_DIGITS:0]   carry;

   assign rise = tick_in & ~tick_d;

   always_comb begin
      all_nines = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[i*DIGIT_W +: DIGIT_W] != BCD_MAX) all_nines = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      inc     = 1'b0;
      sat_hit = 1'b0;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start && !stop) state_d = ST_RUN;
            end
            ST_RUN: begin
               // Saturation wins over a simultaneous stop; otherwise the rise still counts.
               if (rise && all_nines && (STOP_AT_MAX != 0)) begin
                  sat_hit = 1'b1;
                  state_d = ST_FULL;
               end else begin
                  inc = rise;
                  if (stop) state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start && !stop) state_d = ST_RUN;
            end
            ST_FULL: begin
               state_d = ST_FULL;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign carry[0] = inc;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .reset     (reset),
         .clr       (clear),
         .inc_in    (carry[g]),
         .digit     (bcd[g*DIGIT_W +: DIGIT_W]),
         .carry_out (carry[g+1])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_d     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_d     <= tick_in;
         // Carry out of the top decade is the wrap event; saturation never propagates a carry.
         overflow_q <= sat_hit | carry[NUM_DIGITS];
      end
   end

   assign running  = (state_q == ST_RUN);
   assign full     = (state_q == ST_FULL);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed self-checking bench: a 4-decade saturating instance plus 2-decade
// saturating and wrapping instances driven from a shared control set.
module tb_bcd_tick_counter;

   logic        clk;
   logic        reset;

   logic        tick4, start4, stop4, clear4;
   logic        use_div, div_en, div_q;
   logic [3:0]  div_cnt;
   logic        tick4_in;
   logic [15:0] bcd4;
   logic        running4, full4, ovf4;

   logic        tick2, start2, stop2, clear2;
   logic [7:0]  bcd_s, bcd_w;
   logic        running_s, full_s, ovf_s;
   logic        running_w, full_w, ovf_w;

   logic        bad_digit;
   int          checks;
   int          errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural divide-by-10 stage: output toggles every 10 clk, period 20 clk.
   always @(posedge clk) begin
      if (!div_en) begin
         div_cnt <= 4'd0;
         div_q   <= 1'b0;
      end else if (div_cnt == 4'd9) begin
         div_cnt <= 4'd0;
         div_q   <= ~div_q;
      end else begin
         div_cnt <= div_cnt + 4'd1;
      end
   end

   assign tick4_in = use_div ? div_q : tick4;

   bcd_tick_counter #(.NUM_DIGITS(4), .STOP_AT_MAX(1)) dut4 (
      .clk(clk), .reset(reset), .tick_in(tick4_in), .start(start4), .stop(stop4),
      .clear(clear4), .bcd(bcd4), .running(running4), .full(full4), .overflow(ovf4)
   );

   bcd_tick_counter #(.NUM_DIGITS(2), .STOP_AT_MAX(1)) dut2s (
      .clk(clk), .reset(reset), .tick_in(tick2), .start(start2), .stop(stop2),
      .clear(clear2), .bcd(bcd_s), .running(running_s), .full(full_s), .overflow(ovf_s)
   );

   bcd_tick_counter #(.NUM_DIGITS(2), .STOP_AT_MAX(0)) dut2w (
      .clk(clk), .reset(reset), .tick_in(tick2), .start(start2), .stop(stop2),
      .clear(clear2), .bcd(bcd_w), .running(running_w), .full(full_w), .overflow(ovf_w)
   );

   // Sticky monitor: no decade of any instance may ever hold 10..15.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) if (bcd4[i*4 +: 4] > 4'd9) bad_digit <= 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (bcd_s[i*4 +: 4] > 4'd9) bad_digit <= 1'b1;
         if (bcd_w[i*4 +: 4] > 4'd9) bad_digit <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse4();
      tick4 = 1'b1;
      @(negedge clk);
      tick4 = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse2();
      tick2 = 1'b1;
      @(negedge clk);
      tick2 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0; errors = 0; bad_digit = 1'b0;
      reset = 1'b0;
      tick4 = 0; start4 = 0; stop4 = 0; clear4 = 0; use_div = 0; div_en = 0;
      tick2 = 0; start2 = 0; stop2 = 0; clear2 = 0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_bcd", bcd4, 32'h0);
      check("reset_running", running4, 0);
      check("reset_full", full4, 0);
      check("reset_overflow", ovf4, 0);

      // Basic count from the divider: rises counted 11, 31, ... 191 cycles in.
      start4 = 1;
      @(negedge clk);
      start4 = 0; use_div = 1; div_en = 1;
      check("basic_running", running4, 1);
      repeat (200) @(negedge clk);
      check("basic_200clk", bcd4, 32'h0010);
      stop4 = 1;
      @(negedge clk);
      stop4 = 0;
      repeat (100) @(negedge clk);
      check("stop_frozen", bcd4, 32'h0010);
      check("stop_not_running", running4, 0);
      div_en = 0; use_div = 0;
      @(negedge clk);

      // One increment per held level, one cycle after the rise.
      start4 = 1;
      @(negedge clk);
      start4 = 0;
      tick4 = 1;
      check("level_pre_edge", bcd4, 32'h0010);
      @(negedge clk);
      check("level_after_edge", bcd4, 32'h0011);
      repeat (50) @(negedge clk);
      check("level_held", bcd4, 32'h0011);
      tick4 = 0;
      @(negedge clk);

      // Carry chain boundaries.
      repeat (88) pulse4();
      check("carry_0099", bcd4, 32'h0099);
      pulse4();
      check("carry_0100", bcd4, 32'h0100);
      repeat (899) pulse4();
      check("carry_0999", bcd4, 32'h0999);
      pulse4();
      check("carry_1000", bcd4, 32'h1000);

      // stop + rise in the same cycle: counted, then PAUSE.
      stop4 = 1; tick4 = 1;
      @(negedge clk);
      stop4 = 0; tick4 = 0;
      check("stop_rise_bcd", bcd4, 32'h1001);
      check("stop_rise_paused", running4, 0);
      @(negedge clk);

      // clear beats start and rise.
      clear4 = 1; start4 = 1; tick4 = 1;
      @(negedge clk);
      clear4 = 0; start4 = 0; tick4 = 0;
      check("clear_prio_bcd", bcd4, 32'h0);
      check("clear_prio_running", running4, 0);
      @(negedge clk);

      // Asynchronous reset mid-count.
      start4 = 1;
      @(negedge clk);
      start4 = 0;
      repeat (12) pulse4();
      check("pre_reset_bcd", bcd4, 32'h0012);
      check("pre_reset_running", running4, 1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_bcd", bcd4, 32'h0);
      check("async_reset_running", running4, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Two-decade saturate vs wrap at 99.
      start2 = 1;
      @(negedge clk);
      start2 = 0;
      repeat (99) pulse2();
      check("sat_at_99", bcd_s, 32'h99);
      check("wrap_at_99", bcd_w, 32'h99);
      check("sat_not_full_yet", full_s, 0);
      tick2 = 1;
      @(negedge clk);
      tick2 = 0;
      check("sat_hold_99", bcd_s, 32'h99);
      check("sat_full", full_s, 1);
      check("sat_not_running", running_s, 0);
      check("sat_overflow", ovf_s, 1);
      check("wrap_to_00", bcd_w, 32'h00);
      check("wrap_overflow", ovf_w, 1);
      check("wrap_running", running_w, 1);
      check("wrap_not_full", full_w, 0);
      @(negedge clk);
      check("sat_overflow_drop", ovf_s, 0);
      check("wrap_overflow_drop", ovf_w, 0);
      start2 = 1; tick2 = 1;
      @(negedge clk);
      start2 = 0; tick2 = 0;
      check("full_ignores_rise", bcd_s, 32'h99);
      check("full_stays", full_s, 1);
      check("full_no_overflow", ovf_s, 0);
      check("wrap_counts_on", bcd_w, 32'h01);
      @(negedge clk);
      clear2 = 1;
      @(negedge clk);
      clear2 = 0;
      check("sat_clear_bcd", bcd_s, 32'h00);
      check("sat_clear_full", full_s, 0);
      check("sat_clear_idle", running_s, 0);
      check("wrap_clear_bcd", bcd_w, 32'h00);
      check("wrap_clear_idle", running_w, 0);

      check("no_digit_over_9", bad_digit, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Decimal event counter directly downstream of the divide-by-10 clock stage.
- Samples that stage's divided output as a level in the `clk` domain and detects its rising edges.
- Counts edges in packed BCD under start/stop/clear control.
- Feeds the display/readout logic with stable digits plus running, full and overflow status.

Parameters:
- NUM_DIGITS, 4, number of BCD decades (legal 1..8).
- STOP_AT_MAX, 1, 1 = saturate at all-9s and enter FULL; 0 = wrap to zero and keep running.

Ports:
- clk  input  1  system clock; same clock that drives the divider.
- reset  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided-clock level from the divider; synchronous to clk, so no synchronizer.
- start  input  1  level, sampled each clk: begin or resume counting.
- stop  input  1  level, sampled each clk: pause counting.
- clear  input  1  level, sampled each clk: zero count, return to IDLE.
- bcd  output  4*NUM_DIGITS  packed BCD count; digit 0 in bits [3:0].
- running  output  1  high while in RUN.
- full  output  1  high while in FULL.
- overflow  output  1  one-cycle pulse when a rise arrives at all-9s in RUN.

Behaviour:
- Reset (reset low, async): state=IDLE, bcd=0, tick_d=0, running=0, full=0, overflow=0. Reset mid-count discards the count immediately.
- Edge detect: tick_d <= tick_in every cycle; rise = tick_in & ~tick_d.
  - A level held high for many cycles yields exactly one rise.
  - A tick already high when reset releases counts as a rise on the first clock.
- Latency: bcd updates on the clk edge that samples tick_in=1, tick_d=0, i.e. one cycle after tick_in rises.
  - With the divider feeding tick_in, one increment occurs every 20 clk cycles.
- FSM states: IDLE, RUN, PAUSE, FULL. All outputs are registered.
- Priority per cycle: clear > stop > start.
- clear (any state): next state IDLE, bcd=0, overflow=0. A rise in the same cycle is ignored.
- IDLE: start & ~stop -> RUN. Rises are ignored.
- RUN:
  - On rise, increment bcd.
  - stop -> PAUSE. A rise in the same cycle as stop is still counted.
  - start while already in RUN has no effect.
- PAUSE: rises are ignored, count is held. start & ~stop -> RUN.
- FULL: count held at all-9s; start, stop and rises are ignored; only clear exits.
- Increment rules:
  - Each decade counts 0..9.
  - Carry into decade k+1 only when decades 0..k are all 9.
  - No decade may ever hold a value of 10..15.
- Max boundary, rise in RUN with bcd = all 9s:
  - STOP_AT_MAX=1: bcd holds all 9s, next state FULL, overflow=1 for one cycle.
  - STOP_AT_MAX=0: bcd wraps to 0, stays RUN, overflow=1 for one cycle.
  - If stop occurs in the same cycle: wrap/saturate still happens, then PAUSE (STOP_AT_MAX=0) or FULL (STOP_AT_MAX=1; FULL beats PAUSE).
- Output decode: running = (state==RUN); full = (state==FULL); overflow deasserts the cycle after it is asserted.

Decomposition:
- Shared package:
  - state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_FULL=2'd3;
  - BCD_MAX=4'd9;
  - digit width constant 4.
- One sub-module, bcd_digit: single decade register.
  - Inputs: clk, reset, clr, inc_in.
  - Outputs: digit[3:0], carry_out = inc_in & (digit==9).
  - Top level instantiates NUM_DIGITS of these in a generate chain.
  - FSM, edge detect and overflow logic stay in the top level.

Test Plan:
- Basic count: drive tick_in from freq_div_10 on the same clk; start pulse; run 200 clk -> bcd=16'h0010, running=1; stop -> count frozen over another 100 clk.
- Single count per level: hold tick_in high 50 cycles in RUN -> exactly one increment; bcd changes one cycle after the rise.
- Carry chain: count to 0099, one rise -> 0100; count to 0999, one rise -> 1000; no digit ever exceeds 9 (assertion).
- Saturate (NUM_DIGITS=2, STOP_AT_MAX=1): at 99 apply a rise -> bcd=8'h99, full=1, overflow high exactly one cycle; further start/rises -> no change; clear -> bcd=00, IDLE.
- Wrap (NUM_DIGITS=2, STOP_AT_MAX=0): at 99 apply a rise -> bcd=00, overflow one-cycle pulse, running stays 1.
- Collisions and reset:
  - RUN with stop+rise in the same cycle -> count +1, then PAUSE.
  - clear+start+rise in the same cycle -> IDLE, bcd=0.
  - reset low mid-count at 0012 -> bcd=0, running=0 immediately, without waiting for a clock edge.
